// File: rtl/fetch_pkg.sv
// Shared definitions for the IF-stage fetch sequencer: FSM encoding,
// next-PC select codes, default constants and target alignment helpers.
package fetch_pkg;

    localparam logic [1:0] ST_ENC_RST_HOLD = 2'd0;
    localparam logic [1:0] ST_ENC_FETCH    = 2'd1;
    localparam logic [1:0] ST_ENC_DRAIN    = 2'd2;

    typedef enum logic [1:0] {
        ST_RST_HOLD = ST_ENC_RST_HOLD,
        ST_FETCH    = ST_ENC_FETCH,
        ST_DRAIN    = ST_ENC_DRAIN
    } fetch_state_e;

    // Source of the next PC presented to the ProgramCounter.
    typedef enum logic [2:0] {
        NPC_RESET    = 3'd0,
        NPC_HOLD     = 3'd1,
        NPC_INC      = 3'd2,
        NPC_REDIRECT = 3'd3,
        NPC_PENDING  = 3'd4
    } npc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_INC       = 32'd4;
    localparam logic [31:0] NOP_WORD             = 32'h0000_0000;

    // Instruction fetches are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_mux.sv
// Next-PC selection: resolves branch/jump priority and picks between the
// reset vector, hold, sequential increment, redirect and pending target.
module next_pc_mux
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] PC_INC       = DEFAULT_PC_INC
) (
    input  npc_sel_e    sel_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pend_target_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] address_o,
    output logic        redirect_o,
    output logic [31:0] redirect_target_o,
    output logic        redirect_misaligned_o
);

    logic [31:0] raw_target;

    // Branch resolves in EX and is older than the ID-stage jump, so it wins.
    always_comb begin
        redirect_o            = branch_taken_i | jump_i;
        raw_target            = branch_taken_i ? branch_target_i : jump_target_i;
        redirect_target_o     = align_word(raw_target);
        redirect_misaligned_o = redirect_o & is_misaligned(raw_target);
    end

    // Select the address driven into the ProgramCounter; increment wraps mod 2^32.
    always_comb begin
        address_o = pc_i;
        case (sel_i)
            NPC_RESET:    address_o = RESET_VECTOR;
            NPC_HOLD:     address_o = pc_i;
            NPC_INC:      address_o = pc_i + PC_INC;
            NPC_REDIRECT: address_o = redirect_target_o;
            NPC_PENDING:  address_o = pend_target_i;
            default:      address_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// IF-stage sequencer: drives the next PC, handshakes with a variable-latency
// instruction memory, and parks redirects that arrive while a fetch is in
// flight until that fetch drains.
module pc_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] PC_INC       = DEFAULT_PC_INC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    output logic [31:0] Address,
    output logic        ImemReq,
    input  logic        ImemReady,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        Misaligned
);

    fetch_state_e state_q, state_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic         misaligned_q, misaligned_d;

    npc_sel_e     npc_sel;
    logic         redirect;
    logic [31:0]  redirect_target;
    logic         redirect_misaligned;
    logic         redirect_accept;

    next_pc_mux #(
        .RESET_VECTOR (RESET_VECTOR),
        .PC_INC       (PC_INC)
    ) u_next_pc_mux (
        .sel_i                 (npc_sel),
        .pc_i                  (PCResult),
        .pend_target_i         (pend_target_q),
        .branch_taken_i        (BranchTaken),
        .branch_target_i       (BranchTarget),
        .jump_i                (Jump),
        .jump_target_i         (JumpTarget),
        .address_o             (Address),
        .redirect_o            (redirect),
        .redirect_target_o     (redirect_target),
        .redirect_misaligned_o (redirect_misaligned)
    );

    // Next-state and output decode; Reset overrides everything at the end.
    always_comb begin
        state_d         = state_q;
        pend_valid_d    = pend_valid_q;
        pend_target_d   = pend_target_q;
        npc_sel         = NPC_HOLD;
        ImemReq         = 1'b0;
        IFIDWrite       = 1'b0;
        IFIDFlush       = 1'b1;
        redirect_accept = 1'b0;

        case (state_q)
            ST_RST_HOLD: begin
                npc_sel = NPC_RESET;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                ImemReq = 1'b1;
                if (redirect) begin
                    redirect_accept = 1'b1;
                    IFIDFlush       = 1'b1;
                    if (ImemReady) begin
                        npc_sel = NPC_REDIRECT;
                    end else begin
                        // Fetch still outstanding: keep its address stable, park the target.
                        npc_sel       = NPC_HOLD;
                        pend_target_d = redirect_target;
                        pend_valid_d  = 1'b1;
                        state_d       = ST_DRAIN;
                    end
                end else if (Stall) begin
                    npc_sel   = NPC_HOLD;
                    IFIDFlush = 1'b0;
                end else if (ImemReady) begin
                    npc_sel   = NPC_INC;
                    IFIDWrite = 1'b1;
                    IFIDFlush = 1'b0;
                end else begin
                    npc_sel = NPC_HOLD;
                end
            end

            ST_DRAIN: begin
                ImemReq = 1'b1;
                npc_sel = NPC_HOLD;
                if (redirect) begin
                    redirect_accept = 1'b1;
                    pend_target_d   = redirect_target;
                end
                if (ImemReady) begin
                    // Wrong-path data is dropped; a same-cycle redirect is the newest target.
                    if (redirect) begin
                        npc_sel = NPC_REDIRECT;
                    end else if (pend_valid_q) begin
                        npc_sel = NPC_PENDING;
                    end else begin
                        npc_sel = NPC_HOLD;
                    end
                    pend_valid_d = 1'b0;
                    state_d      = ST_FETCH;
                end
            end

            default: begin
                npc_sel = NPC_RESET;
                state_d = ST_RST_HOLD;
            end
        endcase

        if (Reset) begin
            state_d         = ST_RST_HOLD;
            pend_valid_d    = 1'b0;
            npc_sel         = NPC_RESET;
            ImemReq         = 1'b0;
            IFIDWrite       = 1'b0;
            IFIDFlush       = 1'b1;
            redirect_accept = 1'b0;
        end

        misaligned_d = redirect_accept & redirect_misaligned;
    end

    // State, pending redirect and misalignment pulse registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_RST_HOLD;
            pend_valid_q  <= 1'b0;
            pend_target_q <= RESET_VECTOR;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign Misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; a simple ProgramCounter register
// closes the loop from Address back to PCResult.
module tb_pc_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCResult = 32'h0;
    logic [31:0] Address;
    logic        ImemReq;
    logic        ImemReady;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        Misaligned;

    int checks   = 0;
    int failures = 0;

    pc_fetch_sequencer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PCResult     (PCResult),
        .Address      (Address),
        .ImemReq      (ImemReq),
        .ImemReady    (ImemReady),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .IFIDWrite    (IFIDWrite),
        .IFIDFlush    (IFIDFlush),
        .Misaligned   (Misaligned)
    );

    always #5 Clk = ~Clk;

    // External ProgramCounter: loads Address every cycle.
    always @(posedge Clk) PCResult <= Address;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs mid-cycle, then let combinational outputs settle.
    task automatic step(input logic rst, input logic rdy, input logic stl,
                        input logic bt, input logic [31:0] btgt,
                        input logic j, input logic [31:0] jtgt);
        @(negedge Clk);
        Reset        = rst;
        ImemReady    = rdy;
        Stall        = stl;
        BranchTaken  = bt;
        BranchTarget = btgt;
        Jump         = j;
        JumpTarget   = jtgt;
        #1;
    endtask

    task automatic expo(input string tag, input logic [31:0] addr,
                        input logic req, input logic wr, input logic fl);
        chk({tag, ".Address"},   Address,   addr);
        chk({tag, ".ImemReq"},   {31'd0, ImemReq},   {31'd0, req});
        chk({tag, ".IFIDWrite"}, {31'd0, IFIDWrite}, {31'd0, wr});
        chk({tag, ".IFIDFlush"}, {31'd0, IFIDFlush}, {31'd0, fl});
        $display("step %-12s pc=%h addr=%h req=%b wr=%b fl=%b mis=%b",
                 tag, PCResult, Address, ImemReq, IFIDWrite, IFIDFlush, Misaligned);
    endtask

    initial begin
        Reset = 1'b1; ImemReady = 1'b1; Stall = 1'b0;
        BranchTaken = 1'b0; BranchTarget = 32'h0; Jump = 1'b0; JumpTarget = 32'h0;

        // Reset held two cycles with ImemReady tied high, then sequential fetch
        step(1, 1, 0, 0, 0, 0, 0); expo("t1_rst0", 32'h0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0); expo("t1_rst1", 32'h0, 0, 0, 1);
        chk("t1_mis_rst", {31'd0, Misaligned}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0); expo("t1_hold", 32'h0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0); expo("t1_pc0", 32'h4, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0); expo("t1_pc4", 32'h8, 1, 1, 0);

        // Stall at PC=8 for three cycles
        step(0, 1, 1, 0, 0, 0, 0); expo("t2_stall0", 32'h8, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0); expo("t2_stall1", 32'h8, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0); expo("t2_stall2", 32'h8, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0); expo("t2_go", 32'hC, 1, 1, 0);

        // Ready every third cycle from PC=0x10
        step(0, 1, 0, 0, 0, 0, 0); expo("t3_pcC", 32'h10, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0); expo("t3_wait0", 32'h10, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0); expo("t3_wait1", 32'h10, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0); expo("t3_rdy10", 32'h14, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0); expo("t3_wait2", 32'h14, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0); expo("t3_wait3", 32'h14, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0); expo("t3_rdy14", 32'h18, 1, 1, 0);

        // Branch while PC=0x20 is outstanding: drain, discard, then target
        step(0, 1, 0, 0, 0, 0, 0); expo("t4_pc18", 32'h1C, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0); expo("t4_pc1C", 32'h20, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0); expo("t4_wait", 32'h20, 1, 0, 1);
        step(0, 0, 0, 1, 32'h100, 0, 0); expo("t4_branch", 32'h20, 1, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0); expo("t4_drain", 32'h20, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0); expo("t4_discard", 32'h100, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0); expo("t4_pc100", 32'h104, 1, 1, 0);

        // Branch and jump together with stall and ready: branch wins
        step(0, 1, 1, 1, 32'h200, 1, 32'h300); expo("t5_both", 32'h200, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0); expo("t5_pc200", 32'h204, 1, 1, 0);
        chk("t5_mis", {31'd0, Misaligned}, 32'd0);

        // Misaligned jump target, then reset during a drain
        step(0, 1, 0, 0, 0, 1, 32'h403); expo("t6_jump", 32'h400, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0); expo("t6_wait", 32'h400, 1, 0, 1);
        chk("t6_mis_pulse", {31'd0, Misaligned}, 32'd1);
        step(0, 0, 0, 1, 32'h500, 0, 0); expo("t6_branch", 32'h400, 1, 0, 1);
        chk("t6_mis_clear", {31'd0, Misaligned}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 32'h600); expo("t6_drainjmp", 32'h400, 1, 0, 1);
        chk("t6_pend_set", {31'd0, dut.pend_valid_q}, 32'd1);
        step(1, 1, 0, 0, 0, 0, 0); expo("t6_rst", 32'h0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0); expo("t6_rsthold", 32'h0, 0, 0, 1);
        chk("t6_pend_clr", {31'd0, dut.pend_valid_q}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0); expo("t6_pc0", 32'h4, 1, 1, 0);

        // Redirect arriving in DRAIN on the ready cycle, and PC wrap
        step(0, 0, 0, 1, 32'h700, 0, 0); expo("t7_branch", 32'h4, 1, 0, 1);
        step(0, 1, 0, 0, 0, 1, 32'h801); expo("t7_drainrdy", 32'h800, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0); expo("t7_pc800", 32'h804, 1, 1, 0);
        chk("t7_mis", {31'd0, Misaligned}, 32'd1);
        step(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC); expo("t7_jtop", 32'hFFFF_FFFC, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0); expo("t7_wrap", 32'h0, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
